// File: rtl/wrr_req_tracker_if.sv
// Arbiter-side bus of the WRR pending-request tracker: request pushes,
// per-requestor status, the arbiter grant/ack handshake and the downstream
// grant ID. The master modport is the arbiter/producer side; the tracker
// uses the slave modport.
interface wrr_req_tracker_if #(
  parameter int N_REQ = 32,
  parameter int ID_W  = 5
);
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] full;
  logic [N_REQ-1:0] ovf;
  logic             ovf_clr;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt_w;
  logic [ID_W-1:0]  gnt_id;
  logic             ack;
  logic             out_vld;
  logic [ID_W-1:0]  out_id;
  logic             err;

  modport master (
    output push, ovf_clr, gnt_w, gnt_id,
    input  full, ovf, req, ack, out_vld, out_id, err
  );

  modport slave (
    input  push, ovf_clr, gnt_w, gnt_id,
    output full, ovf, req, ack, out_vld, out_id, err
  );
endinterface

// File: rtl/wrr_req_tracker.sv
// Per-requestor pending-request tracker feeding a weighted round-robin
// arbiter. Each requestor owns a saturating counter of outstanding requests;
// req[i] is raised while its counter is nonzero. An eligible grant is accepted
// with a one-cycle ack, retires one request and forwards the granted ID.
// After an ack the next cycle ignores the grant, so at most one grant is
// accepted every two cycles.
//
// Optional feature: define WRR_REQ_TRACKER_CHECK_EN to require gnt_w to be
// exactly one-hot at gnt_id. Inconsistent grants are then rejected and
// flagged on err. Without it, gnt_w only qualifies that a grant is present.
module wrr_req_tracker #(
  parameter int N_REQ = 32,
  parameter int ID_W  = 5,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  wrr_req_tracker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q [N_REQ];
  logic [CNT_W-1:0] count_d [N_REQ];
  logic [N_REQ-1:0] ovf_q;
  logic [N_REQ-1:0] ovf_d;
  logic [N_REQ-1:0] ovf_set;
  logic [N_REQ-1:0] dec;
  logic             ack_q;
  logic             err_q;
  logic [ID_W-1:0]  out_id_q;

  logic             gnt_window;
  logic             gnt_ok;
  logic             cnt_zero;
  logic             accept;
  logic             err_d;

  // Grant qualification: decide whether this cycle's grant is accepted or
  // reported as a protocol error.
  // NOTE: every always_comb output gets a default at the top, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    gnt_window = (|bus.gnt_w) && !ack_q;
    cnt_zero   = (count_q[bus.gnt_id] == '0);
`ifdef WRR_REQ_TRACKER_CHECK_EN
    gnt_ok     = (bus.gnt_w == ({{(N_REQ-1){1'b0}}, 1'b1} << bus.gnt_id));
`else
    gnt_ok     = 1'b1;
`endif
    accept     = gnt_window && gnt_ok && !cnt_zero;
    err_d      = gnt_window && (!gnt_ok || cnt_zero);
  end

  // Counter next state. A push and a decrement on the same requestor cancel.
  // A push at max without a decrement is dropped and flags overflow.
  always_comb begin
    dec     = '0;
    ovf_set = '0;
    for (int i = 0; i < N_REQ; i++) begin
      count_d[i] = count_q[i];
      dec[i]     = accept && (bus.gnt_id == ID_W'(i));
      if (bus.push[i] && !dec[i]) begin
        if (count_q[i] == CNT_MAX) ovf_set[i] = 1'b1;
        else                       count_d[i] = count_q[i] + 1'b1;
      end else if (dec[i] && !bus.push[i]) begin
        count_d[i] = count_q[i] - 1'b1;
      end
    end
    // A new overflow wins over a same-cycle clear.
    ovf_d = (ovf_q & {N_REQ{~bus.ovf_clr}}) | ovf_set;
  end

  // State registers with synchronous reset.
  // NOTE: the counter array is reset explicitly, because reset must discard
  // every pending request and not only the control flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) count_q[i] <= '0;
      ovf_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      out_id_q <= '0;
    end else begin
      // NOTE: sequential state uses only non-blocking assignments, so every
      // register samples its pre-edge value.
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ack_q   <= accept;
      err_q   <= err_d;
      if (accept) out_id_q <= bus.gnt_id;
    end
  end

  // Arbiter-facing request and full vectors, decoded from the registered counts.
  always_comb begin
    bus.req  = '0;
    bus.full = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req[i]  = (count_q[i] != '0);
      bus.full[i] = (count_q[i] == CNT_MAX);
    end
  end

  assign bus.ovf     = ovf_q;
  assign bus.ack     = ack_q;
  assign bus.out_vld = ack_q;
  assign bus.out_id  = out_id_q;
  assign bus.err     = err_q;

endmodule
